block_data_memory: RTL and testbench

Parametrised block-granular backing memory behind the data cache. It serves whole cache blocks of BLOCK_BYTES bytes with a programmable, counter-based access latency and a busywait handshake. It adds per-byte write masking, explicit block-address wrap-around and detection of illegal simultaneous read/write requests. It connects directly to the data cache's memory-side port.

---
 rtl/block_data_memory_if.sv | 35 +++
 rtl/block_data_memory.sv | 132 +++++++++++++
 tb/tb_block_data_memory.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/block_data_memory_if.sv
// Block memory port between the data cache (master) and the backing memory (slave).
// Latency: none; this is wiring only.
// Backpressure: the slave holds busywait high while a request is pending or in service.
//
// Signals:
//   read, write   : block read / block write request from the cache
//   address       : block address (upper bits beyond the memory depth are ignored)
//   writedata     : write block, byte i at bits [8i+7:8i]
//   writemask     : per-byte write enable, bit i gates byte i
//   readdata      : registered read block
//   busywait      : request pending or in service
//   error         : one-cycle pulse after an illegal read+write request
interface block_data_memory_if #(
   parameter int BLOCK_BYTES = 16,
   parameter int ADDR_WIDTH  = 28
);
   logic                     read;
   logic                     write;
   logic [ADDR_WIDTH-1:0]    address;
   logic [8*BLOCK_BYTES-1:0] writedata;
   logic [BLOCK_BYTES-1:0]   writemask;
   logic [8*BLOCK_BYTES-1:0] readdata;
   logic                     busywait;
   logic                     error;

   modport master (
      output read, write, address, writedata, writemask,
      input  readdata, busywait, error
   );

   modport slave (
      input  read, write, address, writedata, writemask,
      output readdata, busywait, error
   );
endinterface

// File: rtl/block_data_memory.sv
// Block-granular backing memory behind the data cache, with per-byte write masking.
// Latency: request seen in IDLE, LATENCY busy cycles, then one DONE cycle; LATENCY+2 cycles minimum period.
// Backpressure: busywait is high from the request cycle until DONE; inputs are ignored after capture.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset; clears state, readdata, error and the whole store
//   mem   : block memory port (slave side), see block_data_memory_if
module block_data_memory #(
   parameter int BLOCK_BYTES  = 16,
   parameter int ADDR_WIDTH   = 28,
   parameter int DEPTH_BLOCKS = 64,
   parameter int LATENCY      = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   block_data_memory_if.slave    mem
);

   localparam int IDX_W  = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int DATA_W = 8 * BLOCK_BYTES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 op_wr_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [BLOCK_BYTES-1:0] wmask_q;
   logic [DATA_W-1:0]    rdata_q;
   logic                 err_q;

   logic [DATA_W-1:0]    store [DEPTH_BLOCKS];

   logic                 capture;
   logic                 commit;
   logic                 illegal;
   logic                 busy;

   // Exactly one of read/write is a legal request; both together is flagged and dropped.
   logic single_req;
   assign single_req = mem.read ^ mem.write;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      commit  = 1'b0;
      illegal = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (single_req) begin
               capture = 1'b1;
               busy    = 1'b1;
               state_d = BUSY;
            end else if (mem.read && mem.write) begin
               illegal = 1'b1;
            end
         end
         BUSY: begin
            busy = 1'b1;
            // The access lands on the edge that ends the last busy cycle,
            // so a read issued right after a write sees the new data.
            if (cnt_q == '0) begin
               commit  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Requests seen here belong to the access just finished.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int b = 0; b < DEPTH_BLOCKS; b++) begin
            store[b] <= '0;
         end
      end else begin
         state_q <= state_d;
         err_q   <= illegal;

         if (capture) begin
            op_wr_q <= mem.write;
            // Upper address bits are dropped: addresses wrap modulo the depth.
            idx_q   <= mem.address[IDX_W-1:0];
            wdata_q <= mem.writedata;
            wmask_q <= mem.writemask;
            cnt_q   <= CNT_W'(LATENCY - 1);
         end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end

         if (commit) begin
            if (op_wr_q) begin
               for (int i = 0; i < BLOCK_BYTES; i++) begin
                  if (wmask_q[i]) begin
                     store[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                  end
               end
            end else begin
               rdata_q <= store[idx_q];
            end
         end
      end
   end

   assign mem.readdata = rdata_q;
   assign mem.error    = err_q;
   assign mem.busywait = busy;

endmodule

// File: tb/tb_block_data_memory.sv
// Randomized bench for block_data_memory against a byte-array reference model.
// Latency: each access is timed cycle by cycle from the request cycle to DONE.
// Backpressure: the bench holds its request until busywait drops, scrambling other inputs meanwhile.
module tb_block_data_memory;

   localparam int BB    = 16;
   localparam int AW    = 28;
   localparam int DEPTH = 64;
   localparam int LAT   = 5;
   localparam int W     = 8 * BB;

   typedef logic [W-1:0] blk_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   block_data_memory_if #(.BLOCK_BYTES(BB), .ADDR_WIDTH(AW)) bus ();

   block_data_memory #(
      .BLOCK_BYTES (BB),
      .ADDR_WIDTH  (AW),
      .DEPTH_BLOCKS(DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .mem  (bus.slave)
   );

   always #5 clock = ~clock;

   // Reference model: memory as an array of bytes, plus the last block read.
   logic [7:0] mdl_mem [DEPTH][BB];
   blk_t       mdl_rd;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input blk_t got, input blk_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic blk_t rnd_blk();
      blk_t b;
      b = '0;
      for (int i = 0; i < BB / 4; i++) begin
         b[32*i +: 32] = $urandom;
      end
      return b;
   endfunction

   function automatic blk_t mdl_block(input int idx);
      blk_t b;
      b = '0;
      for (int i = 0; i < BB; i++) begin
         b[8*i +: 8] = mdl_mem[idx][i];
      end
      return b;
   endfunction

   task automatic mdl_clear();
      for (int b = 0; b < DEPTH; b++) begin
         for (int i = 0; i < BB; i++) begin
            mdl_mem[b][i] = 8'h00;
         end
      end
      mdl_rd = '0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bus.read  = 1'b0;
      bus.write = 1'b0;
      step();
      step();
      @(negedge clock);
      chk("rst_busy", blk_t'(bus.busywait), blk_t'(0));
      chk("rst_err", blk_t'(bus.error), blk_t'(0));
      chk("rst_rdata", bus.readdata, '0);
      mdl_clear();
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_busy", blk_t'(bus.busywait), blk_t'(0));
   endtask

   // One complete access: request in cycle 0, hold until busywait drops, check DONE, release.
   task automatic access(input bit wr, input logic [AW-1:0] a, input blk_t d, input logic [BB-1:0] m);
      int  busy_n;
      bit  done;
      int  idx;
      step();
      bus.read      = !wr;
      bus.write     = wr;
      bus.address   = a;
      bus.writedata = d;
      bus.writemask = m;
      busy_n = 0;
      done   = 0;
      for (int c = 0; c < LAT + 8 && !done; c++) begin
         @(negedge clock);
         if (bus.busywait) begin
            busy_n++;
            chk("rdata_hold_busy", bus.readdata, mdl_rd);
            step();
            // Captured values must win over whatever the inputs do now.
            bus.address   = AW'($urandom);
            bus.writedata = rnd_blk();
            bus.writemask = BB'($urandom);
         end else begin
            done = 1;
         end
      end
      idx = int'(a % DEPTH);
      if (wr) begin
         for (int i = 0; i < BB; i++) begin
            if (m[i]) mdl_mem[idx][i] = d[8*i +: 8];
         end
      end else begin
         mdl_rd = mdl_block(idx);
      end
      chk(wr ? "wr_busy_cycles" : "rd_busy_cycles", blk_t'(busy_n), blk_t'(LAT + 1));
      chk(wr ? "wr_done_rdata" : "rd_done_rdata", bus.readdata, mdl_rd);
      chk("done_err", blk_t'(bus.error), blk_t'(0));
      step();
      bus.read  = 1'b0;
      bus.write = 1'b0;
   endtask

   task automatic illegal_req(input int cycles);
      step();
      bus.read      = 1'b1;
      bus.write     = 1'b1;
      bus.address   = AW'($urandom);
      bus.writedata = rnd_blk();
      bus.writemask = '1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clock);
         chk("ill_busy", blk_t'(bus.busywait), blk_t'(0));
         chk("ill_err", blk_t'(bus.error), blk_t'(c > 0));
         step();
      end
      bus.read  = 1'b0;
      bus.write = 1'b0;
      @(negedge clock);
      chk("ill_err_last", blk_t'(bus.error), blk_t'(1));
      step();
      @(negedge clock);
      chk("ill_err_clr", blk_t'(bus.error), blk_t'(0));
      chk("ill_rdata", bus.readdata, mdl_rd);
   endtask

   blk_t ramp;
   blk_t tmp;

   initial begin
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.address   = '0;
      bus.writedata = '0;
      bus.writemask = '0;
      mdl_clear();

      do_reset();

      // Read of a freshly cleared block.
      access(1'b0, AW'(3), '0, '0);
      chk("t1_rd3_zero", bus.readdata, '0);

      // Full-mask write of a byte ramp, then read back.
      for (int i = 0; i < BB; i++) ramp[8*i +: 8] = 8'(i);
      access(1'b1, AW'(5), ramp, '1);
      access(1'b0, AW'(5), '0, '0);
      tmp = 128'h0F0E0D0C0B0A09080706050403020100;
      chk("t2_rd5_ramp", bus.readdata, tmp);

      // Single-byte masked write.
      access(1'b1, AW'(5), {BB{8'hAA}}, BB'(1));
      access(1'b0, AW'(5), '0, '0);
      tmp = 128'h0F0E0D0C0B0A090807060504030201AA;
      chk("t3_rd5_mask", bus.readdata, tmp);

      // Address wrap: 66 mod 64 = 2.
      access(1'b1, AW'(2), {BB{8'h55}}, '1);
      access(1'b0, AW'(66), '0, '0);
      chk("t4_wrap", bus.readdata, {BB{8'h55}});

      // Illegal simultaneous request, held for two cycles.
      illegal_req(2);
      access(1'b0, AW'(5), '0, '0);

      // Reset during the third busy cycle of a write to block 7.
      step();
      bus.write     = 1'b1;
      bus.address   = AW'(7);
      bus.writedata = rnd_blk();
      bus.writemask = '1;
      @(negedge clock);
      chk("t6_busy_c0", blk_t'(bus.busywait), blk_t'(1));
      step();
      step();
      step();
      reset     = 1'b1;
      bus.write = 1'b0;
      step();
      reset = 1'b0;
      mdl_clear();
      @(negedge clock);
      chk("t6_busy_after_rst", blk_t'(bus.busywait), blk_t'(0));
      chk("t6_err_after_rst", blk_t'(bus.error), blk_t'(0));
      chk("t6_rdata_after_rst", bus.readdata, '0);
      access(1'b0, AW'(7), '0, '0);
      chk("t6_rd7_aborted", bus.readdata, '0);

      // Random traffic against the model.
      for (int n = 0; n < 40; n++) begin
         int op;
         logic [AW-1:0] a;
         op = int'($urandom_range(0, 9));
         if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 3 * DEPTH));
         else                            a = AW'($urandom);
         if (op == 0)      illegal_req(int'($urandom_range(1, 3)));
         else if (op <= 4) access(1'b1, a, rnd_blk(), BB'($urandom));
         else              access(1'b0, a, '0, '0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
